// File: rtl/mdc_fft_ctrl.sv
// Sequencing controller for a radix-2 multi-path delay commutator FFT pipeline.
// Defining MDC_FFT_CTRL_OUTREG_EN adds one extra register stage on every output.
module mdc_fft_ctrl #(
    parameter int LOG2N = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic [LOG2N-1:0]           stage_en,
    output logic [LOG2N-1:0]           com_sel,
    output logic [LOG2N*(LOG2N-1)-1:0] tw_addr,
    output logic                       out_valid,
    output logic                       frame_done
);

    localparam int          N    = 1 << LOG2N;
    localparam int          W    = LOG2N - 1;
    localparam int          TW   = LOG2N * W;
    localparam int unsigned NU   = N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    // Start offset of stage s: N - 2*D_s, with D_s = 2^(LOG2N-1-s).
    function automatic int unsigned stage_off(input int unsigned s);
        return NU - (32'd1 << (LOG2N - s));
    endfunction

    logic [LOG2N-1:0] a_cnt, a_nxt;
    logic [LOG2N-1:0] f_cnt, f_nxt;
    logic [LOG2N-1:0] en_r, en_nxt;
    logic [LOG2N-1:0] com_r, com_nxt;
    logic [TW-1:0]    tw_r, tw_nxt;
    logic             ov_r, ov_nxt;
    logic             fd_r, fd_nxt;

    // Every O_s is a multiple of 2*D_s and 2*D_s divides N, so the stage phase
    // (a - O_s) mod 2*D_s reduces to the low LOG2N-s bits of the frame position.
    always_comb begin
        a_nxt   = a_cnt;
        f_nxt   = f_cnt;
        en_nxt  = en_r;
        com_nxt = com_r;
        tw_nxt  = tw_r;
        ov_nxt  = 1'b0;
        fd_nxt  = 1'b0;
        if (in_valid) begin
            a_nxt  = (a_cnt == LAST) ? a_cnt : a_cnt + 1'b1;
            f_nxt  = f_cnt + 1'b1;
            ov_nxt = (a_cnt == LAST);
            fd_nxt = (f_cnt == LAST);
            for (int unsigned s = 0; s < LOG2N; s++) begin
                en_nxt[s]        = en_r[s] | (32'(a_cnt) >= stage_off(s));
                com_nxt[s]       = en_nxt[s] & f_cnt[W - s];
                tw_nxt[s*W +: W] = en_nxt[s] ? W'(f_cnt[W-1:0] << s) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= '0;
            f_cnt <= '0;
            en_r  <= '0;
            com_r <= '0;
            tw_r  <= '0;
            ov_r  <= 1'b0;
            fd_r  <= 1'b0;
        end else if (clr) begin
            a_cnt <= '0;
            f_cnt <= '0;
            en_r  <= '0;
            com_r <= '0;
            tw_r  <= '0;
            ov_r  <= 1'b0;
            fd_r  <= 1'b0;
        end else begin
            a_cnt <= a_nxt;
            f_cnt <= f_nxt;
            en_r  <= en_nxt;
            com_r <= com_nxt;
            tw_r  <= tw_nxt;
            ov_r  <= ov_nxt;
            fd_r  <= fd_nxt;
        end
    end

`ifdef MDC_FFT_CTRL_OUTREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_en   <= '0;
            com_sel    <= '0;
            tw_addr    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (clr) begin
            stage_en   <= '0;
            com_sel    <= '0;
            tw_addr    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            stage_en   <= en_r;
            com_sel    <= com_r;
            tw_addr    <= tw_r;
            out_valid  <= ov_r;
            frame_done <= fd_r;
        end
    end
`else
    assign stage_en   = en_r;
    assign com_sel    = com_r;
    assign tw_addr    = tw_r;
    assign out_valid  = ov_r;
    assign frame_done = fd_r;
`endif

endmodule

// File: tb/tb_mdc_fft_ctrl.sv
// Randomized bench for mdc_fft_ctrl at LOG2N = 3, 5 and 8 against an arithmetic model.
module tb_mdc_fft_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clr, in_valid;

    logic [2:0]  en3, com3;
    logic [5:0]  tw3;
    logic        ov3, fd3;
    logic [4:0]  en5, com5;
    logic [19:0] tw5;
    logic        ov5, fd5;
    logic [7:0]  en8, com8;
    logic [55:0] tw8;
    logic        ov8, fd8;

    mdc_fft_ctrl #(.LOG2N(3)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .stage_en(en3), .com_sel(com3), .tw_addr(tw3), .out_valid(ov3), .frame_done(fd3)
    );
    mdc_fft_ctrl #(.LOG2N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .stage_en(en5), .com_sel(com5), .tw_addr(tw5), .out_valid(ov5), .frame_done(fd5)
    );
    mdc_fft_ctrl #(.LOG2N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .stage_en(en8), .com_sel(com8), .tw_addr(tw8), .out_valid(ov8), .frame_done(fd8)
    );

`ifdef MDC_FFT_CTRL_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [63:0] en;
        logic [63:0] com;
        logic [63:0] tw;
        logic        ov;
        logic        fd;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;          // samples accepted since reset/clr
    int   lgs[3] = '{3, 5, 8};
    exp_t now_e[3];
    exp_t del_e[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs after the c-th accepted sample; acc marks a sample taken this edge.
    function automatic exp_t calc(input int lg, input int c, input bit acc);
        exp_t e;
        int n, a, d, o, p;
        n = 1 << lg;
        e.en = '0; e.com = '0; e.tw = '0; e.ov = 1'b0; e.fd = 1'b0;
        if (c > 0) begin
            a = c - 1;
            for (int s = 0; s < lg; s++) begin
                d = 1 << (lg - 1 - s);
                o = n - 2 * d;
                if (a >= o) begin
                    p = (a - o) % (2 * d);
                    e.en[s]  = 1'b1;
                    e.com[s] = (p >= d);
                    e.tw     = e.tw | ((64'((p % d) << s)) << (s * (lg - 1)));
                end
            end
            if (acc) begin
                e.ov = (a >= n - 1);
                e.fd = ((a % n) == n - 1);
            end
        end
        return e;
    endfunction

    function automatic exp_t zero_e();
        return calc(3, 0, 1'b0);
    endfunction

    task automatic cmp_inst(input int i, input exp_t e);
        string t;
        t = $sformatf("lg%0d", lgs[i]);
        case (i)
            0: begin
                check({t, "_en"}, 64'(en3), e.en);  check({t, "_com"}, 64'(com3), e.com);
                check({t, "_tw"}, 64'(tw3), e.tw);  check({t, "_ov"}, 64'(ov3), 64'(e.ov));
                check({t, "_fd"}, 64'(fd3), 64'(e.fd));
            end
            1: begin
                check({t, "_en"}, 64'(en5), e.en);  check({t, "_com"}, 64'(com5), e.com);
                check({t, "_tw"}, 64'(tw5), e.tw);  check({t, "_ov"}, 64'(ov5), 64'(e.ov));
                check({t, "_fd"}, 64'(fd5), 64'(e.fd));
            end
            default: begin
                check({t, "_en"}, 64'(en8), e.en);  check({t, "_com"}, 64'(com8), e.com);
                check({t, "_tw"}, 64'(tw8), e.tw);  check({t, "_ov"}, 64'(ov8), 64'(e.ov));
                check({t, "_fd"}, 64'(fd8), 64'(e.fd));
            end
        endcase
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 3; i++)
            cmp_inst(i, (LAT == 1) ? del_e[i] : now_e[i]);
    endtask

    task automatic model_reset();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            now_e[i] = zero_e();
            del_e[i] = zero_e();
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare mid-cycle.
    task automatic step(input bit v, input bit c);
        exp_t prev;
        in_valid = v;
        clr      = c;
        @(posedge clk);
        if (c) cnt = 0;
        else if (v) cnt++;
        for (int i = 0; i < 3; i++) begin
            prev     = now_e[i];
            now_e[i] = calc(lgs[i], cnt, v && !c);
            del_e[i] = c ? zero_e() : prev;
        end
        @(negedge clk);
        cmp_all();
    endtask

    int first_en[5];
    int first_ov;
    int fd_at[$];
    int offs[5] = '{0, 16, 24, 28, 30};

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp_all();
        rst_n = 1'b1;

        // Continuous streaming from reset, with event-time checks on the N=32 instance.
        for (int s = 0; s < 5; s++) first_en[s] = -1;
        first_ov = -1;
        for (int j = 0; j < 100; j++) begin
            step(1'b1, 1'b0);
            for (int s = 0; s < 5; s++)
                if (first_en[s] < 0 && en5[s]) first_en[s] = j;
            if (first_ov < 0 && ov5) first_ov = j;
            if (fd5) fd_at.push_back(j);
        end
        for (int s = 0; s < 5; s++)
            check($sformatf("en_rise%0d", s), 64'(first_en[s]), 64'(offs[s] + LAT));
        check("ov_first", 64'(first_ov), 64'(31 + LAT));
        check("fd_count", 64'(fd_at.size()), 64'd3);
        for (int k = 0; k < fd_at.size() && k < 3; k++)
            check($sformatf("fd_at%0d", k), 64'(fd_at[k]), 64'(31 + 32 * k + LAT));

        // Restart, then a three-cycle stall after sample a=20.
        step(1'b1, 1'b1);
        for (int j = 0; j < 21; j++) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        for (int j = 0; j < 30; j++) step(1'b1, 1'b0);

        // clr colliding with a valid sample at a=40.
        step(1'b1, 1'b1);
        for (int j = 0; j < 40; j++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int j = 0; j < 10; j++) step(1'b1, 1'b0);

        // Random gaps and occasional clears.
        for (int j = 0; j < 400; j++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);

        // Asynchronous reset mid-frame, observed before any clock edge.
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all();
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmp_all();
        rst_n = 1'b1;

        // Three full frames of the 256-point instance, back to back.
        for (int j = 0; j < 3 * 256 + 8; j++) step(1'b1, 1'b0);
        for (int j = 0; j < 200; j++)
            step($urandom_range(0, 4) != 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdc_fft_ctrl.md
MDC_FFT_CTRL -- requirements
Module: mdc_fft_ctrl

Interface
REQ-001 The block SHALL have parameter LOG2N, default 5, meaning log2 of FFT points N = 2^LOG2N; the legal range is 3..10.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous restart of all sequencing state.
REQ-005 The block SHALL have port in_valid, input, 1 bit: one input sample accepted this cycle; all sequencing advances only on accepted samples.
REQ-006 The block SHALL have port stage_en, output, LOG2N bits: bit s = stage s active.
REQ-007 The block SHALL have port com_sel, output, LOG2N bits: bit s = stage s commutator swap select.
REQ-008 The block SHALL have port tw_addr, output, LOG2N*(LOG2N-1) bits: slice s = stage s twiddle ROM address into the N-point table.
REQ-009 The block SHALL have port out_valid, output, 1 bit: pipeline output sample valid.
REQ-010 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse on the last sample of each input frame.

Function
REQ-011 Accepted-sample index a SHALL count accepted samples from 0 after reset or clr, saturating internally once all stages are enabled; a separate frame position f = a mod N SHALL wrap N-1 -> 0.
REQ-012 For each stage s (0..LOG2N-1), D_s = 2^(LOG2N-1-s) and start offset O_s = N - 2*D_s (N=32: O = 0,16,24,28,30).
REQ-013 All outputs SHALL be registered; on the edge accepting sample a, stage_en[s] SHALL become 1 if a >= O_s and then stay 1 until reset or clr.
REQ-014 Each enabled stage SHALL hold phase p_s = (a - O_s) mod 2*D_s, and the phase SHALL wrap 2*D_s-1 -> 0 with no gap cycle.
REQ-015 com_sel[s] SHALL equal (p_s >= D_s) while stage s is enabled, else 0.
REQ-016 The tw_addr slice for stage s SHALL equal (p_s mod D_s) << s, zero-extended to LOG2N-1 bits; the last stage always outputs 0.
REQ-017 out_valid SHALL be 1 on the edge accepting sample a when a >= N-1, else 0 (pipeline fill latency N-1 samples).
REQ-018 frame_done SHALL be 1 for exactly one cycle, on the edge accepting a sample with f == N-1.
REQ-019 A cycle with in_valid=0 SHALL hold every counter, stage_en, com_sel and tw_addr, and SHALL drive out_valid=0 and frame_done=0.
REQ-020 clr=1 SHALL win over a simultaneous in_valid: all state returns to reset values and the sample is not counted.
REQ-021 Streaming SHALL be continuous: frames back-to-back without bubbles, and stage phases continue across frame boundaries.

Reset
REQ-022 While rst_n=0, stage_en, com_sel, tw_addr, out_valid, frame_done and all internal counters SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-frame SHALL discard all progress; after release, the first accepted sample is a=0.

Configuration
REQ-024 When macro MDC_FFT_CTRL_OUTREG_EN is defined, every output SHALL pass through one additional register stage, giving all outputs one extra cycle of latency, still cleared by rst_n and clr.
REQ-025 When MDC_FFT_CTRL_OUTREG_EN is undefined, outputs SHALL follow REQ-013..REQ-019 exactly, with no extra register stage.

Verification
REQ-026 LOG2N=5, in_valid held 1 from reset: stage_en SHALL rise bit by bit after samples 0, 16, 24, 28, 30; out_valid SHALL first be 1 at sample 31; frame_done SHALL pulse at samples 31, 63, 95.
REQ-027 LOG2N=5: stage 1 com_sel SHALL be 0 for samples 16..23 and 1 for samples 24..31; its tw_addr SHALL step 0,2,4..14 and then repeat.
REQ-028 LOG2N=5: in_valid low for 3 cycles at a=20 SHALL hold all outputs constant with out_valid=0, then resume at a=21 with the identical sequence.
REQ-029 clr together with in_valid at a=40 SHALL give all outputs 0 next cycle; the next accepted sample SHALL behave as a=0.
REQ-030 LOG2N=3 and LOG2N=8 sweeps SHALL match a reference model of REQ-012..REQ-018 over 3 frames, including wrap at f=N-1.
REQ-031 With MDC_FFT_CTRL_OUTREG_EN defined, each REQ-026 event SHALL occur exactly one cycle later; rst_n low mid-frame SHALL clear both register stages immediately.
